dir_lectura_seq: RTL and testbench

//  Read-side address sequencer for the RTC register bus; the counterpart of the write-address decoder path.
//  On start, walks N_DIR consecutive register addresses from BASE_DIR and issues one req/ack read per address.

---
 rtl/dir_lectura_seq.sv | 97 +++++++++
 tb/tb_dir_lectura_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_lectura_seq.sv
// Read-side address sequencer: walks N_DIR bus addresses from BASE_DIR, issues one
// req/ack read per address and captures each returned byte into its own slot.
module dir_lectura_seq #(
    parameter int          N_DIR       = 7,
    parameter logic [7:0]  BASE_DIR    = 8'h21,
    parameter int          DATA_W      = 8,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      rd_req,
    output logic [7:0]                rd_dir,
    input  logic                      rd_ack,
    input  logic [DATA_W-1:0]         rd_data,
    output logic [N_DIR*DATA_W-1:0]   dat_out,
    output logic [N_DIR-1:0]          cur_onehot,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int IW = (N_DIR > 1) ? $clog2(N_DIR) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIR - 1);
    localparam logic [TW-1:0] LAST_T   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   tcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            tcnt    <= '0;
            rd_req  <= 1'b0;
            rd_dir  <= '0;
            dat_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= REQ;
                        busy   <= 1'b1;
                        idx    <= '0;
                        err    <= 1'b0;
                        tcnt   <= '0;
                        rd_req <= 1'b1;
                        rd_dir <= BASE_DIR;
                    end
                end
                REQ: begin
                    // An ack on the same edge as the timeout still completes the read.
                    if (rd_ack) begin
                        dat_out[idx*DATA_W +: DATA_W] <= rd_data;
                        rd_req <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= GAP;
                        end
                    end else if (tcnt == LAST_T) begin
                        err    <= 1'b1;
                        rd_req <= 1'b0;
                        state  <= DONE;
                        done   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GAP: begin
                    tcnt   <= '0;
                    rd_req <= 1'b1;
                    rd_dir <= BASE_DIR + 8'(idx);
                    state  <= REQ;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cur_onehot = busy ? (N_DIR'(1) << idx) : '0;

endmodule

// File: tb/tb_dir_lectura_seq.sv
// Bench for dir_lectura_seq: randomized bus responder against a slot/latency model.
module tb_dir_lectura_seq;

    localparam int N  = 7;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, rd_ack;
    logic [7:0]      rd_data;
    logic            rd_req;
    logic [7:0]      rd_dir;
    logic [N*DW-1:0] dat_out;
    logic [N-1:0]    cur_onehot;
    logic            busy, done, err;

    logic            start_b, rd_ack_b;
    logic [7:0]      rd_data_b;
    logic            rd_req_b;
    logic [7:0]      rd_dir_b;
    logic [15:0]     dat_out_b;
    logic [1:0]      cur_onehot_b;
    logic            busy_b, done_b, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] slot   [N];
    logic [7:0] slot_b [2];

    always #5 clk = ~clk;

    dir_lectura_seq #(.N_DIR(N), .BASE_DIR(8'h21), .DATA_W(DW), .TIMEOUT_CYC(255)) dut_a (
        .clk(clk), .reset(reset), .start(start), .rd_req(rd_req), .rd_dir(rd_dir),
        .rd_ack(rd_ack), .rd_data(rd_data), .dat_out(dat_out), .cur_onehot(cur_onehot),
        .busy(busy), .done(done), .err(err));

    dir_lectura_seq #(.N_DIR(2), .BASE_DIR(8'hFF), .DATA_W(8), .TIMEOUT_CYC(255)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .rd_req(rd_req_b), .rd_dir(rd_dir_b),
        .rd_ack(rd_ack_b), .rd_data(rd_data_b), .dat_out(dat_out_b), .cur_onehot(cur_onehot_b),
        .busy(busy_b), .done(done_b), .err(err_b));

    function automatic logic [N*DW-1:0] pack_a();
        logic [N*DW-1:0] p;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = slot[i];
        return p;
    endfunction

    // Bus responder: caller is at a negedge inside REQ; returns at the negedge after the ack.
    task automatic serve_slot(input int i, input int dly, input logic [7:0] d);
        rd_ack = 1'b0;
        for (int w = 0; w < dly; w++) begin
            rd_data = 8'($urandom);
            @(negedge clk);
        end
        rd_ack  = 1'b1;
        rd_data = d;
        @(negedge clk);
        rd_ack  = 1'b0;
        slot[i] = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            start = c[0]; rd_ack = ~c[0]; rd_data = 8'($urandom);
            start_b = c[0]; rd_ack_b = ~c[0]; rd_data_b = 8'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({rd_req, rd_dir, dat_out, cur_onehot, busy, done, err} !== '0) begin
                n_bad++;
                $display("FAIL reset_hold_a: got %h want 0", {rd_req, rd_dir, dat_out, cur_onehot, busy, done, err});
            end
            n_cmp++;
            if ({rd_req_b, rd_dir_b, dat_out_b, cur_onehot_b, busy_b, done_b, err_b} !== '0) begin
                n_bad++;
                $display("FAIL reset_hold_b: got %h want 0", {rd_req_b, rd_dir_b, dat_out_b, cur_onehot_b, busy_b, done_b, err_b});
            end
        end
        start = 1'b0; rd_ack = 1'b0; start_b = 1'b0; rd_ack_b = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < N; i++) slot[i] = '0;
        slot_b[0] = '0; slot_b[1] = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rd_req, busy, done, err, rd_req_b, busy_b} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_release: got %b want 000000", {rd_req, busy, done, err, rd_req_b, busy_b});
        end
    endtask

    task automatic test_normal(input bit rnd);
        logic [7:0]   d;
        logic [N-1:0] oh;
        int           dly;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            dly = rnd ? int'($urandom_range(0, 5)) : 3;
            d   = rnd ? 8'($urandom) : 8'(8'h10 + i);
            oh = '0; oh[i] = 1'b1;
            for (int w = 0; w <= dly; w++) begin
                n_cmp++;
                if ({rd_req, rd_dir, cur_onehot, busy, done} !== {1'b1, 8'(8'h21 + i), oh, 1'b1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL req_slot%0d: got req=%b dir=%h oh=%b busy=%b done=%b want req=1 dir=%h oh=%b busy=1 done=0",
                             i, rd_req, rd_dir, cur_onehot, busy, done, 8'(8'h21 + i), oh);
                end
                start   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                rd_ack  = (w == dly);
                rd_data = (w == dly) ? d : 8'($urandom);
                @(negedge clk);
            end
            rd_ack  = 1'b0;
            slot[i] = d;
            n_cmp++;
            if (dat_out !== pack_a()) begin
                n_bad++;
                $display("FAIL dat_slot%0d: got %h want %h", i, dat_out, pack_a());
            end
            if (i < N - 1) begin
                n_cmp++;
                if ({rd_req, busy, done} !== 3'b010) begin
                    n_bad++;
                    $display("FAIL gap_slot%0d: got req/busy/done=%b want 010", i, {rd_req, busy, done});
                end
                @(negedge clk);
            end else begin
                start = 1'b0;
                n_cmp++;
                if ({rd_req, busy, done, err} !== 4'b0110) begin
                    n_bad++;
                    $display("FAIL done_pulse: got req/busy/done/err=%b want 0110", {rd_req, busy, done, err});
                end
                @(negedge clk);
                n_cmp++;
                if ({rd_req, busy, done, cur_onehot} !== '0) begin
                    n_bad++;
                    $display("FAIL back_idle: got %b want 0", {rd_req, busy, done, cur_onehot});
                end
            end
        end
    endtask

    // Ack held high throughout: REQ must occupy the odd cycles 1..2N-1 and done cycle 2N.
    task automatic test_zero_wait();
        logic [7:0] dv;
        start  = 1'b1;
        rd_ack = 1'b1;
        rd_data = 8'($urandom);
        for (int k = 1; k <= 2*N + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if ({rd_req, done, busy} !== {((k % 2 == 1) && (k <= 2*N - 1)), (k == 2*N), (k <= 2*N)}) begin
                n_bad++;
                $display("FAIL zw_cycle%0d: got req/done/busy=%b want %b", k, {rd_req, done, busy},
                         {((k % 2 == 1) && (k <= 2*N - 1)), (k == 2*N), (k <= 2*N)});
            end
            dv = 8'($urandom);
            rd_data = dv;
            if ((k % 2 == 1) && (k <= 2*N - 1)) slot[(k - 1) / 2] = dv;
        end
        @(negedge clk);
        rd_ack = 1'b0;
        n_cmp++;
        if ({dat_out, rd_req, busy} !== {pack_a(), 2'b00}) begin
            n_bad++;
            $display("FAIL zw_data: got %h req=%b busy=%b want %h req=0 busy=0", dat_out, rd_req, busy, pack_a());
        end
    endtask

    task automatic test_timeout();
        int cnt;
        bit hit;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            serve_slot(i, int'($urandom_range(0, 3)), 8'($urandom));
            @(negedge clk);
        end
        cnt = 0;
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (rd_req) cnt++;
            rd_data = 8'($urandom);
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit || cnt != 255) begin
            n_bad++;
            $display("FAIL timeout_len: got done=%b req_cycles=%0d want done=1 req_cycles=255", hit, cnt);
        end
        n_cmp++;
        if ({err, rd_req, busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL timeout_flags: got err/req/busy=%b want 101", {err, rd_req, busy});
        end
        n_cmp++;
        if (dat_out !== pack_a()) begin
            n_bad++;
            $display("FAIL timeout_slots: got %h want %h", dat_out, pack_a());
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({err, busy, done} !== 3'b100) begin
            n_bad++;
            $display("FAIL err_sticky: got err/busy/done=%b want 100", {err, busy, done});
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serve_slot(i, int'($urandom_range(0, 2)), 8'($urandom));
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if ({rd_req, rd_dir} !== {1'b1, 8'h25}) begin
            n_bad++;
            $display("FAIL mid_req: got req=%b dir=%h want req=1 dir=25", rd_req, rd_dir);
        end
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) slot[i] = '0;
        slot_b[0] = '0; slot_b[1] = '0;
        n_cmp++;
        if ({rd_req, busy, done, err, rd_dir, cur_onehot, dat_out} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got req=%b busy=%b dir=%h dat=%h want all 0", rd_req, busy, rd_dir, dat_out);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spurious();
        logic [7:0] d0, d1;
        rd_ack_b = 1'b1; rd_data_b = 8'hA5;
        @(negedge clk);
        n_cmp++;
        if ({rd_req_b, busy_b, dat_out_b} !== {2'b00, slot_b[1], slot_b[0]}) begin
            n_bad++;
            $display("FAIL ack_idle: got req=%b busy=%b dat=%h want 0 0 %h", rd_req_b, busy_b, dat_out_b, {slot_b[1], slot_b[0]});
        end
        rd_ack_b = 1'b0; start_b = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rd_req_b, rd_dir_b, cur_onehot_b} !== {1'b1, 8'hFF, 2'b01}) begin
            n_bad++;
            $display("FAIL wrap_slot0: got req=%b dir=%h oh=%b want 1 ff 01", rd_req_b, rd_dir_b, cur_onehot_b);
        end
        d0 = 8'($urandom); d1 = 8'($urandom);
        rd_ack_b = 1'b1; rd_data_b = d0; slot_b[0] = d0;
        @(negedge clk);
        n_cmp++;
        if ({rd_req_b, busy_b, dat_out_b} !== {2'b01, slot_b[1], slot_b[0]}) begin
            n_bad++;
            $display("FAIL gap_b: got req=%b busy=%b dat=%h want 0 1 %h", rd_req_b, busy_b, dat_out_b, {slot_b[1], slot_b[0]});
        end
        rd_data_b = ~d0;
        @(negedge clk);
        n_cmp++;
        if ({rd_req_b, rd_dir_b, cur_onehot_b, dat_out_b} !== {1'b1, 8'h00, 2'b10, slot_b[1], slot_b[0]}) begin
            n_bad++;
            $display("FAIL wrap_slot1: got req=%b dir=%h oh=%b dat=%h want 1 00 10 %h",
                     rd_req_b, rd_dir_b, cur_onehot_b, dat_out_b, {slot_b[1], slot_b[0]});
        end
        rd_data_b = d1; slot_b[1] = d1; start_b = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done_b, busy_b, err_b, dat_out_b} !== {3'b110, slot_b[1], slot_b[0]}) begin
            n_bad++;
            $display("FAIL done_b: got done=%b busy=%b err=%b dat=%h want 1 1 0 %h",
                     done_b, busy_b, err_b, dat_out_b, {slot_b[1], slot_b[0]});
        end
        rd_ack_b = 1'b0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n_cmp++;
        if ({rd_req_b, busy_b, done_b} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_b: got req/busy/done=%b want 000", {rd_req_b, busy_b, done_b});
        end
        @(negedge clk);
        n_cmp++;
        if ({rd_req_b, busy_b} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_in_done: got req/busy=%b want 00", {rd_req_b, busy_b});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; rd_ack = 1'b0; rd_data = '0;
        start_b = 1'b0; rd_ack_b = 1'b0; rd_data_b = '0;
        test_reset();
        test_normal(1'b0);
        test_normal(1'b1);
        test_zero_wait();
        test_timeout();
        test_reset_mid();
        test_normal(1'b1);
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
